// File: rtl/score_overlay.sv
// Score overlay: banks wave scores into a 15-bit total and draws the running
// score as five white seven-segment digits on the VGA overlay.
module score_overlay #(
  parameter int unsigned X0    = 0,
  parameter int unsigned Y0    = 0,
  parameter int unsigned PITCH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        win,
  input  logic [9:0]  vga_x,
  input  logic [8:0]  vga_y,
  input  logic [10:0] wave_score,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam logic [9:0] Y_TOP = 10'(Y0);

  logic [14:0] total_r;
  logic [14:0] disp_s;
  logic [19:0] bcd_r;
  logic [4:0]  pix_s;
  logic [4:0]  pix_r;
  logic [9:0]  dy_s;
  logic        row_in_s;

  // Shift-add-3 over all 15 input bits; the five BCD nibbles end up in sr[34:15].
  function automatic logic [19:0] bin2bcd(input logic [14:0] bin);
    logic [34:0] sr;
    logic [3:0]  nib;
    sr = {20'd0, bin};
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 5; j++) begin
        nib = sr[15+4*j +: 4];
        sr[15+4*j +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
      sr = {sr[33:0], 1'b0};
    end
    return sr[34:15];
  endfunction

  // Segment set per digit value, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_map(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    return segs;
  endfunction

  // Vertical segments overlap the middle row so the glyph has no gaps at cy=3.
  function automatic logic glyph_lit(input logic [6:0] segs, input logic [2:0] cx,
                                     input logic [2:0] cy);
    return (segs[6] && (cy == 3'd0))
        || (segs[5] && (cx == 3'd4) && (cy <= 3'd3))
        || (segs[4] && (cx == 3'd4) && (cy >= 3'd3))
        || (segs[3] && (cy == 3'd6))
        || (segs[2] && (cx == 3'd0) && (cy >= 3'd3))
        || (segs[1] && (cx == 3'd0) && (cy <= 3'd3))
        || (segs[0] && (cy == 3'd3));
  endfunction

  assign disp_s   = total_r + {4'd0, wave_score};
  // Rows above the glyph wrap to large values, so one compare bounds both sides.
  assign dy_s     = {1'b0, vga_y} - Y_TOP;
  assign row_in_s = (dy_s < 10'd7);

  for (genvar k = 0; k < 5; k++) begin : g_digit
    localparam logic [10:0] X_LEFT = 11'(X0 + PITCH * k);
    logic [10:0] dx_s;
    logic        lit_s;

    assign dx_s = {1'b0, vga_x} - X_LEFT;

    // Pixel of digit k: inside its 5x7 cell and on one of its segments.
    always_comb begin
      lit_s = 1'b0;
      if (row_in_s && (dx_s < 11'd5)) begin
        lit_s = glyph_lit(seg_map(bcd_r[4*(4-k) +: 4]), dx_s[2:0], dy_s[2:0]);
      end else begin
        lit_s = 1'b0;
      end
    end

    assign pix_s[k] = lit_s;
  end

  // Score bank, BCD digit register and per-renderer pixel registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_r <= 15'd0;
      bcd_r   <= 20'd0;
      pix_r   <= 5'd0;
    end else begin
      if (win) begin
        total_r <= disp_s;
      end
      bcd_r <= bin2bcd(disp_s);
      pix_r <= pix_s;
    end
  end

  // White when any digit renderer is lit.
  always_comb begin
    r = 8'h00;
    if (|pix_r) begin
      r = 8'hFF;
    end else begin
      r = 8'h00;
    end
    g = r;
    b = r;
  end

endmodule

// File: tb/tb_score_overlay.sv
// Directed self-checking bench for score_overlay: glyph shapes, banking, wrap,
// reset priority and score-to-pixel latency.
module tb_score_overlay;

  logic        clk;
  logic        reset;
  logic        win;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [10:0] wave_score;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       lit;
  } pv_t;

  score_overlay #(.X0(0), .Y0(0), .PITCH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .win        (win),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .wave_score (wave_score),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a coordinate, let one edge pass, return the colour seen 1 ns later.
  task automatic sample(input logic [9:0] x, input logic [8:0] y, output logic [23:0] rgb);
    vga_x = x;
    vga_y = y;
    @(posedge clk);
    #1;
    rgb = {r, g, b};
  endtask

  task automatic test_reset();
    logic [23:0] rgb;
    pv_t v [5];
    v = '{'{10'd0, 9'd0, 1'b1}, '{10'd2, 9'd3, 1'b0}, '{10'd4, 9'd5, 1'b1},
          '{10'd5, 9'd0, 1'b0}, '{10'd6, 9'd0, 1'b1}};
    reset      = 1'b1;
    win        = 1'b0;
    wave_score = 11'd0;
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 10; x++) begin
        sample(10'(x), 9'(y), rgb);
        checks++;
        if (rgb !== 24'h000000) begin
          errors++;
          $display("FAIL reset_sweep (%0d,%0d) got=%h exp=000000", x, y, rgb);
        end
      end
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      sample(v[i].x, v[i].y, rgb);
      checks++;
      if (rgb !== (v[i].lit ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL after_reset (%0d,%0d) got=%h lit=%0d", v[i].x, v[i].y, rgb, v[i].lit);
      end
    end
  endtask

  // Display "01024" from wave_score alone.
  task automatic test_wave_display();
    logic [23:0] rgb;
    pv_t v [9];
    v = '{'{10'd6,  9'd0, 1'b0}, '{10'd10, 9'd0, 1'b1}, '{10'd14, 9'd3, 1'b0},
          '{10'd20, 9'd3, 1'b1}, '{10'd22, 9'd4, 1'b0}, '{10'd18, 9'd5, 1'b1},
          '{10'd26, 9'd0, 1'b0}, '{10'd24, 9'd2, 1'b1}, '{10'd26, 9'd3, 1'b1}};
    wave_score = 11'd1024;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      sample(v[i].x, v[i].y, rgb);
      checks++;
      if (rgb !== (v[i].lit ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL wave_01024 (%0d,%0d) got=%h lit=%0d", v[i].x, v[i].y, rgb, v[i].lit);
      end
    end
    for (int y = 7; y < 10; y++) begin
      for (int x = 0; x < 30; x++) begin
        sample(10'(x), 9'(y), rgb);
        checks++;
        if (rgb !== 24'h000000) begin
          errors++;
          $display("FAIL below_cells (%0d,%0d) got=%h exp=000000", x, y, rgb);
        end
      end
    end
  endtask

  // One win banks 1024; display "02048".
  task automatic test_win();
    logic [23:0] rgb;
    pv_t v [6];
    v = '{'{10'd18, 9'd3, 1'b1}, '{10'd26, 9'd3, 1'b1}, '{10'd8,  9'd3, 1'b1},
          '{10'd14, 9'd3, 1'b0}, '{10'd18, 9'd0, 1'b1}, '{10'd20, 9'd0, 1'b0}};
    win = 1'b1;
    @(posedge clk);
    #1;
    win = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      sample(v[i].x, v[i].y, rgb);
      checks++;
      if (rgb !== (v[i].lit ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL win_02048 (%0d,%0d) got=%h lit=%0d", v[i].x, v[i].y, rgb, v[i].lit);
      end
    end
  endtask

  // 32 back-to-back wins of 1000 give 32000; 32000+1000 wraps to 232.
  task automatic test_back_to_back_wrap();
    logic [23:0] rgb;
    pv_t va [6];
    pv_t vb [6];
    pv_t vc [3];
    va = '{'{10'd0,  9'd3, 1'b1}, '{10'd2,  9'd3, 1'b0}, '{10'd12, 9'd5, 1'b1},
           '{10'd18, 9'd5, 1'b0}, '{10'd22, 9'd5, 1'b1}, '{10'd24, 9'd5, 1'b1}};
    vb = '{'{10'd6,  9'd0, 1'b0}, '{10'd10, 9'd0, 1'b1}, '{10'd8,  9'd3, 1'b0},
           '{10'd12, 9'd5, 1'b1}, '{10'd18, 9'd5, 1'b0}, '{10'd24, 9'd5, 1'b1}};
    vc = '{'{10'd8, 9'd3, 1'b0}, '{10'd6, 9'd5, 1'b1}, '{10'd18, 9'd5, 1'b0}};
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    wave_score = 11'd1000;
    win        = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    win = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // total 32000, disp 232: "00232", not "33000"
    for (int i = 0; i < 6; i++) begin
      sample(va[i].x, va[i].y, rgb);
      checks++;
      if (rgb !== (va[i].lit ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL wrap_disp_00232 (%0d,%0d) got=%h lit=%0d", va[i].x, va[i].y, rgb, va[i].lit);
      end
    end
    win = 1'b1;
    @(posedge clk);
    #1;
    win = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // total 232, disp 1232: "01232"
    for (int i = 0; i < 6; i++) begin
      sample(vb[i].x, vb[i].y, rgb);
      checks++;
      if (rgb !== (vb[i].lit ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL wrap_total_01232 (%0d,%0d) got=%h lit=%0d", vb[i].x, vb[i].y, rgb, vb[i].lit);
      end
    end
    wave_score = 11'd0;
    win        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    win = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // wins with zero wave leave total at 232: "00232"
    for (int i = 0; i < 3; i++) begin
      sample(vc[i].x, vc[i].y, rgb);
      checks++;
      if (rgb !== (vc[i].lit ? 24'hFFFFFF : 24'h000000)) begin
        errors++;
        $display("FAIL zero_win_00232 (%0d,%0d) got=%h lit=%0d", vc[i].x, vc[i].y, rgb, vc[i].lit);
      end
    end
  endtask

  // Reset and win together: reset wins, total clears, rgb dark next cycle.
  task automatic test_reset_win();
    logic [23:0] rgb;
    sample(10'd6, 9'd5, rgb);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL pre_reset_lit got=%h exp=ffffff", rgb);
    end
    reset      = 1'b1;
    win        = 1'b1;
    wave_score = 11'd500;
    @(posedge clk);
    #1;
    checks++;
    if ({r, g, b} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_win_rgb got=%h exp=000000", {r, g, b});
    end
    reset      = 1'b0;
    win        = 1'b0;
    wave_score = 11'd0;
    repeat (2) @(posedge clk);
    #1;
    sample(10'd18, 9'd5, rgb);
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL reset_win_total0 (18,5) got=%h exp=ffffff", rgb);
    end
    sample(10'd26, 9'd3, rgb);
    checks++;
    if (rgb !== 24'h000000) begin
      errors++;
      $display("FAIL reset_win_total0 (26,3) got=%h exp=000000", rgb);
    end
  endtask

  // Fixed coordinate (26,3): ones digit middle bar, off for "0", on for "8".
  task automatic test_latency();
    logic [23:0] exp_seq [4];
    exp_seq = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    vga_x      = 10'd26;
    vga_y      = 9'd3;
    wave_score = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({r, g, b} !== 24'h000000) begin
      errors++;
      $display("FAIL latency_idle got=%h exp=000000", {r, g, b});
    end
    for (int phase = 0; phase < 2; phase++) begin
      wave_score = (phase == 0) ? 11'd8 : 11'd0;
      for (int c = 0; c < 2; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if ({r, g, b} !== exp_seq[2*phase+c]) begin
          errors++;
          $display("FAIL latency phase=%0d clk=%0d got=%h exp=%h",
                   phase, c + 1, {r, g, b}, exp_seq[2*phase+c]);
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    win        = 1'b0;
    vga_x      = 10'd0;
    vga_y      = 9'd0;
    wave_score = 11'd0;
    #2;
    test_reset();
    test_wave_display();
    test_win();
    test_back_to_back_wrap();
    test_reset_win();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
